// File: rtl/rc4_key_checker.sv
// RC4 key checker: runs the RC4 key schedule for a candidate key, decrypts a
// ciphertext ROM byte by byte, writes each plaintext byte to a result RAM and
// stops at the first byte that is not a lower-case letter or a space.
module rc4_key_checker #(
  parameter int MSG_LEN   = 32,
  parameter int KEY_BYTES = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [KEY_BYTES*8-1:0]       secret_key,
  output logic [$clog2(MSG_LEN)-1:0]   msg_addr,
  input  logic [7:0]                   msg_data,
  output logic                         dec_we,
  output logic [$clog2(MSG_LEN)-1:0]   dec_addr,
  output logic [7:0]                   dec_data,
  output logic                         busy,
  output logic                         finish,
  output logic                         valid
);

  localparam int AW  = $clog2(MSG_LEN);
  localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    KSA    = 3'd2,
    P_ADDR = 3'd3,
    P_SWAP = 3'd4,
    P_XOR  = 3'd5,
    DONE   = 3'd6
  } state_e;

  // Plaintext bytes accepted as a sign of a correct key.
  function automatic logic is_legal(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  // Key byte 0 is the most significant byte of the key word.
  function automatic logic [7:0] key_byte(input logic [KEY_BYTES*8-1:0] key,
                                          input logic [KIW-1:0]         idx);
    logic [7:0] b;
    b = 8'h00;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (idx == KIW'(n)) begin
        b = key[(KEY_BYTES-1-n)*8 +: 8];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

  state_e                 state_q, state_d;
  logic [7:0]             i_q, i_d;
  logic [7:0]             j_q, j_d;
  logic [AW-1:0]          k_q, k_d;
  logic [KEY_BYTES*8-1:0] key_q, key_d;
  logic [KIW-1:0]         kidx_q, kidx_d;
  logic                   busy_q, busy_d;
  logic                   finish_q, finish_d;
  logic                   valid_q, valid_d;
  logic                   dec_we_q, dec_we_d;
  logic [AW-1:0]          dec_addr_q, dec_addr_d;
  logic [7:0]             dec_data_q, dec_data_d;
  logic [AW-1:0]          msg_addr_q, msg_addr_d;

  // Permutation state; never reset because INIT rewrites every entry.
  logic [7:0]             s_q [256];

  logic                   s_init_s;
  logic                   s_swap_s;
  logic [7:0]             swap_j_s;
  logic [7:0]             si_s;
  logic [7:0]             sj_s;
  logic [7:0]             d_s;
  logic                   accept_s;

  assign si_s     = s_q[i_q];
  assign sj_s     = s_q[j_q];
  assign d_s      = s_q[8'(si_s + sj_s)] ^ msg_data;
  assign accept_s = start && !busy_q;

  // Next-state, datapath and output decisions for every FSM state.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    key_d      = key_q;
    kidx_d     = kidx_q;
    busy_d     = busy_q;
    finish_d   = finish_q;
    valid_d    = valid_q;
    dec_we_d   = 1'b0;
    dec_addr_d = dec_addr_q;
    dec_data_d = dec_data_q;
    msg_addr_d = msg_addr_q;
    s_init_s   = 1'b0;
    s_swap_s   = 1'b0;
    swap_j_s   = j_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          key_d    = secret_key;
          finish_d = 1'b0;
          valid_d  = 1'b0;
          busy_d   = 1'b1;
          i_d      = 8'd0;
          state_d  = INIT;
        end else if (state_q == DONE) begin
          finish_d = 1'b1;
          busy_d   = 1'b0;
        end else begin
          busy_d   = 1'b0;
        end
      end
      INIT: begin
        s_init_s = 1'b1;
        i_d      = i_q + 8'd1;
        if (i_q == 8'd255) begin
          j_d     = 8'd0;
          kidx_d  = KIW'(0);
          state_d = KSA;
        end else begin
          state_d = INIT;
        end
      end
      KSA: begin
        swap_j_s = j_q + si_s + key_byte(key_q, kidx_q);
        s_swap_s = 1'b1;
        i_d      = i_q + 8'd1;
        if (kidx_q == KIW'(KEY_BYTES-1)) begin
          kidx_d = KIW'(0);
        end else begin
          kidx_d = kidx_q + KIW'(1);
        end
        if (i_q == 8'd255) begin
          j_d     = 8'd0;
          k_d     = AW'(0);
          state_d = P_ADDR;
        end else begin
          j_d     = swap_j_s;
          state_d = KSA;
        end
      end
      P_ADDR: begin
        i_d        = i_q + 8'd1;
        msg_addr_d = k_q;
        state_d    = P_SWAP;
      end
      P_SWAP: begin
        swap_j_s = j_q + si_s;
        s_swap_s = 1'b1;
        j_d      = swap_j_s;
        state_d  = P_XOR;
      end
      P_XOR: begin
        dec_we_d   = 1'b1;
        dec_addr_d = k_q;
        dec_data_d = d_s;
        if (!is_legal(d_s)) begin
          valid_d = 1'b0;
          state_d = DONE;
        end else if (k_q == AW'(MSG_LEN-1)) begin
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          k_d     = k_q + AW'(1);
          state_d = P_ADDR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      i_q        <= 8'd0;
      j_q        <= 8'd0;
      k_q        <= AW'(0);
      key_q      <= '0;
      kidx_q     <= KIW'(0);
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
      valid_q    <= 1'b0;
      dec_we_q   <= 1'b0;
      dec_addr_q <= AW'(0);
      dec_data_q <= 8'd0;
      msg_addr_q <= AW'(0);
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      key_q      <= key_d;
      kidx_q     <= kidx_d;
      busy_q     <= busy_d;
      finish_q   <= finish_d;
      valid_q    <= valid_d;
      dec_we_q   <= dec_we_d;
      dec_addr_q <= dec_addr_d;
      dec_data_q <= dec_data_d;
      msg_addr_q <= msg_addr_d;
    end
  end

  // Permutation update: identity fill during INIT, swap of S[i]/S[j] otherwise.
  always_ff @(posedge clk) begin
    if (s_init_s) begin
      s_q[i_q] <= i_q;
    end else if (s_swap_s) begin
      s_q[i_q]      <= s_q[swap_j_s];
      s_q[swap_j_s] <= s_q[i_q];
    end
  end

  assign msg_addr = msg_addr_q;
  assign dec_we   = dec_we_q;
  assign dec_addr = dec_addr_q;
  assign dec_data = dec_data_q;
  assign busy     = busy_q;
  assign finish   = finish_q;
  assign valid    = valid_q;

endmodule

// File: doc/rc4_key_checker.md
RC4_KEY_CHECKER -- requirements
Module: rc4_key_checker

Interface
REQ-001 Parameter MSG_LEN, default 32, number of ciphertext bytes checked per key.
REQ-002 Parameter KEY_BYTES, default 3, number of key bytes; the key is secret_key[23:0], and key byte 0 is secret_key[23:16].
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to check secret_key; sampled synchronously.
REQ-006 secret_key  input  24  candidate key; captured on an accepted start.
REQ-007 msg_addr  output  5  ciphertext ROM address.
REQ-008 msg_data  input  8  ciphertext ROM data; valid exactly 1 cycle after msg_addr.
REQ-009 dec_we / dec_addr / dec_data  output  1/5/8  plaintext write port for the result RAM.
REQ-010 busy  output  1  high from the cycle after an accepted start until finish rises.
REQ-011 finish  output  1  check complete; held until the next accepted start or reset.
REQ-012 valid  output  1  key produced all-legal plaintext; meaningful only while finish=1.

Function
REQ-013 start SHALL be accepted only when busy=0; accepting start captures secret_key, clears finish and valid, and enters INIT.
REQ-014 start while busy=1 SHALL be ignored, with no effect on state or the captured key.
REQ-015 Internal S SHALL be a 256x8 register array, and the indices i and j SHALL be 8 bits with modulo-256 wrap-around.
REQ-016 States SHALL be IDLE, INIT, KSA, P_ADDR, P_SWAP, P_XOR, DONE.
REQ-017 INIT: S[i]=i for i=0..255, one write per cycle, 256 cycles; then j=0 and enter KSA.
REQ-018 KSA, for i=0..255, one iteration per cycle, 256 cycles:
- j = j + S[i] + key[i mod 3];
- swap S[i] and S[j].
REQ-019 After KSA, i and j SHALL both be 0, k SHALL be 0, and the block enters P_ADDR.
REQ-020 P_ADDR: i=i+1; msg_addr=k.
REQ-021 P_SWAP: j=j+S[i]; swap S[i] and S[j].
REQ-022 P_XOR: plaintext byte d = S[S[i]+S[j]] XOR msg_data, using post-swap S; dec_we=1, dec_addr=k, dec_data=d for exactly this cycle.
REQ-023 Each PRGA byte SHALL take exactly 3 cycles.
REQ-024 A legal byte SHALL be 0x61..0x7A or 0x20.
REQ-025 If d is illegal, the next state SHALL be DONE with valid=0; remaining bytes are not processed.
REQ-026 If d is legal and k<MSG_LEN-1: k=k+1, return to P_ADDR.
REQ-027 If d is legal and k=MSG_LEN-1: enter DONE with valid=1.
REQ-028 Timing, with start accepted at edge 0:
- INIT occupies edges 1..256;
- KSA occupies edges 257..512;
- the PRGA byte k P_XOR is at edge 515+3k;
- on a full pass, finish=1 after edge 609 (MSG_LEN=32).
REQ-029 On an abort at byte k, finish=1 after edge 516+3k.
REQ-030 DONE SHALL assert finish=1 and busy=0, hold valid stable, and accept start as in REQ-013.
REQ-031 The key value 0xFFFFFF SHALL need no special handling.
REQ-032 dec_we SHALL be 0 in every state except P_XOR.

Reset
REQ-033 With reset_n=0, asynchronously:
- state=IDLE;
- busy=0, finish=0, valid=0;
- dec_we=0, dec_addr=0, dec_data=0, msg_addr=0;
- i=j=k=0; captured key=0.
REQ-034 S contents SHALL be undefined after reset; INIT always rewrites them before use.
REQ-035 Reset asserted mid-operation SHALL abandon the check without asserting finish.
REQ-036 After reset deasserts, the block SHALL remain idle until a new start.

Verification
REQ-037 Reset: assert reset_n=0 mid-cycle -> outputs zero immediately; start held low -> busy=0, finish=0 indefinitely.
REQ-038 Correct key: ROM = RC4(key 0x000123) of 32 legal chars, start with 0x000123 -> busy=1 from edge 1, 32 dec_we pulses carrying the plaintext, finish=1 and valid=1 after edge 609.
REQ-039 Wrong key: ROM producing byte 0 = 0x41 under key 0x000000 -> exactly one dec_we pulse, finish=1 and valid=0 after edge 516.
REQ-040 Start while busy: second start with key 0xABCDEF at edge 100 -> ignored; result and timing identical to REQ-038.
REQ-041 Reset mid-KSA: reset_n=0 at edge 300, release, start with 0x000123 -> full correct result, no stale S influence.
REQ-042 Restart from DONE: start with key 0xFFFFFF in the cycle finish is high -> finish and valid clear next cycle, and the new check completes with a result matching the reference model.
